// File: rtl/traffic_phase_decoder.sv
// Decodes the 1 s cycle-counter index into two-approach lamp drives, countdowns and BCD digits.
// A broken index sequence forces flashing-yellow fault mode until the counter comes back to 0.
module traffic_phase_decoder #(
    parameter int G_A    = 30,
    parameter int Y_A    = 4,
    parameter int G_B    = 21,
    parameter int Y_B    = 4,
    parameter int PERIOD = 59
) (
    input  logic       clk_1s,
    input  logic       rst,
    input  logic [6:0] number,
    output logic       a_red,
    output logic       a_yel,
    output logic       a_grn,
    output logic       b_red,
    output logic       b_yel,
    output logic       b_grn,
    output logic [6:0] a_remain,
    output logic [6:0] b_remain,
    output logic [3:0] a_tens,
    output logic [3:0] a_ones,
    output logic [3:0] b_tens,
    output logic [3:0] b_ones,
    output logic       fault
);

    typedef enum logic [2:0] {A_GRN, A_YEL, B_GRN, B_YEL, FLT} state_t;

    localparam logic [6:0] L_AG = 7'(G_A);
    localparam logic [6:0] L_AY = 7'(G_A + Y_A);
    localparam logic [6:0] L_BG = 7'(G_A + Y_A + G_B);
    localparam logic [6:0] L_P  = 7'(PERIOD);

    localparam logic [3:0] RST_A_TENS = 4'(G_A / 10);
    localparam logic [3:0] RST_A_ONES = 4'(G_A % 10);
    localparam logic [3:0] RST_B_TENS = 4'((G_A + Y_A) / 10);
    localparam logic [3:0] RST_B_ONES = 4'((G_A + Y_A) % 10);

    state_t     state;
    state_t     phase;
    logic [6:0] n_q;
    logic [6:0] expected;
    logic       seq_err;
    logic       go_flt;
    logic       flash;
    logic       flash_nxt;
    logic [6:0] a_rem_nxt;
    logic [6:0] b_rem_nxt;
    logic [3:0] a_tens_nxt;
    logic [3:0] a_ones_nxt;
    logic [3:0] b_tens_nxt;
    logic [3:0] b_ones_nxt;

    always_comb begin
        expected = (n_q == L_P - 7'd1) ? 7'd0 : n_q + 7'd1;
        seq_err  = (number != expected) || (number >= L_P);
        // In fault mode only a sampled 0 resynchronises; everything else keeps flashing.
        go_flt    = (state == FLT) ? (number != 7'd0) : seq_err;
        flash_nxt = (state == FLT) ? ~flash : 1'b1;

        phase     = B_YEL;
        a_rem_nxt = L_P - number;
        b_rem_nxt = L_P - number;
        if (number < L_AG) begin
            phase     = A_GRN;
            a_rem_nxt = L_AG - number;
            b_rem_nxt = L_AY - number;
        end else if (number < L_AY) begin
            phase     = A_YEL;
            a_rem_nxt = L_AY - number;
            b_rem_nxt = L_AY - number;
        end else if (number < L_BG) begin
            phase     = B_GRN;
            b_rem_nxt = L_BG - number;
        end

        a_tens_nxt = 4'(a_rem_nxt / 7'd10);
        a_ones_nxt = 4'(a_rem_nxt % 7'd10);
        b_tens_nxt = 4'(b_rem_nxt / 7'd10);
        b_ones_nxt = 4'(b_rem_nxt % 7'd10);
    end

    always_ff @(posedge clk_1s or posedge rst) begin
        if (rst) begin
            state    <= A_GRN;
            n_q      <= L_P - 7'd1;
            flash    <= 1'b0;
            a_red    <= 1'b0;
            a_yel    <= 1'b0;
            a_grn    <= 1'b1;
            b_red    <= 1'b1;
            b_yel    <= 1'b0;
            b_grn    <= 1'b0;
            a_remain <= L_AG;
            b_remain <= L_AY;
            a_tens   <= RST_A_TENS;
            a_ones   <= RST_A_ONES;
            b_tens   <= RST_B_TENS;
            b_ones   <= RST_B_ONES;
            fault    <= 1'b0;
        end else begin
            n_q <= number;
            if (go_flt) begin
                state    <= FLT;
                flash    <= flash_nxt;
                a_red    <= 1'b0;
                a_yel    <= flash_nxt;
                a_grn    <= 1'b0;
                b_red    <= 1'b0;
                b_yel    <= flash_nxt;
                b_grn    <= 1'b0;
                a_remain <= 7'd0;
                b_remain <= 7'd0;
                a_tens   <= 4'hF;
                a_ones   <= 4'hF;
                b_tens   <= 4'hF;
                b_ones   <= 4'hF;
                fault    <= 1'b1;
            end else begin
                state    <= phase;
                flash    <= 1'b0;
                a_grn    <= (phase == A_GRN);
                a_yel    <= (phase == A_YEL);
                a_red    <= (phase == B_GRN) || (phase == B_YEL);
                b_red    <= (phase == A_GRN) || (phase == A_YEL);
                b_grn    <= (phase == B_GRN);
                b_yel    <= (phase == B_YEL);
                a_remain <= a_rem_nxt;
                b_remain <= b_rem_nxt;
                a_tens   <= a_tens_nxt;
                a_ones   <= a_ones_nxt;
                b_tens   <= b_tens_nxt;
                b_ones   <= b_ones_nxt;
                fault    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_decoder.sv
// Directed bench for traffic_phase_decoder: full cycles, wrap, sequence faults, async reset.
module tb_traffic_phase_decoder;

    logic       clk_1s;
    logic       rst;
    logic [6:0] number;
    logic       a_red, a_yel, a_grn, b_red, b_yel, b_grn;
    logic [6:0] a_remain, b_remain;
    logic [3:0] a_tens, a_ones, b_tens, b_ones;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;

    bit m_flt;
    bit m_flash;
    int m_nq;

    traffic_phase_decoder dut (
        .clk_1s  (clk_1s),
        .rst     (rst),
        .number  (number),
        .a_red   (a_red),
        .a_yel   (a_yel),
        .a_grn   (a_grn),
        .b_red   (b_red),
        .b_yel   (b_yel),
        .b_grn   (b_grn),
        .a_remain(a_remain),
        .b_remain(b_remain),
        .a_tens  (a_tens),
        .a_ones  (a_ones),
        .b_tens  (b_tens),
        .b_ones  (b_ones),
        .fault   (fault)
    );

    initial clk_1s = 1'b0;
    always #5 clk_1s = ~clk_1s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flt   = 1'b0;
        m_flash = 1'b0;
        m_nq    = 58;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_lamps"}, 32'({a_red, a_yel, a_grn, b_red, b_yel, b_grn}), 32'b001100);
        chk({tag, "_a_rem"}, 32'(a_remain), 30);
        chk({tag, "_b_rem"}, 32'(b_remain), 34);
        chk({tag, "_bcd"}, 32'({a_tens, a_ones, b_tens, b_ones}), 32'h3034);
        chk({tag, "_fault"}, 32'(fault), 0);
    endtask

    // Expected outputs for the sampled index n, hand-derived from 30/4/21/4 timing.
    task automatic check_all(input int n);
        logic [5:0] lamps;
        int ar, br;
        if (m_flt) begin
            lamps = {1'b0, m_flash, 1'b0, 1'b0, m_flash, 1'b0};
            ar = 0; br = 0;
        end else if (n < 30) begin
            lamps = 6'b001100; ar = 30 - n; br = 34 - n;
        end else if (n < 34) begin
            lamps = 6'b010100; ar = 34 - n; br = 34 - n;
        end else if (n < 55) begin
            lamps = 6'b100001; ar = 59 - n; br = 55 - n;
        end else begin
            lamps = 6'b100010; ar = 59 - n; br = 59 - n;
        end
        chk($sformatf("lamps_n%0d", n), 32'({a_red, a_yel, a_grn, b_red, b_yel, b_grn}), 32'(lamps));
        chk($sformatf("a_rem_n%0d", n), 32'(a_remain), 32'(ar));
        chk($sformatf("b_rem_n%0d", n), 32'(b_remain), 32'(br));
        chk($sformatf("fault_n%0d", n), 32'(fault), 32'(m_flt));
        chk("excl_two_grn", 32'(a_grn & b_grn), 0);
        chk("excl_a_grn_red", 32'(a_grn & a_red), 0);
        chk("excl_b_grn_red", 32'(b_grn & b_red), 0);
        if (m_flt) begin
            chk("bcd_blank", 32'({a_tens, a_ones, b_tens, b_ones}), 32'hFFFF);
        end else begin
            chk($sformatf("a_bcd_n%0d", n), 32'({a_tens, a_ones}), 32'({4'(ar / 10), 4'(ar % 10)}));
            chk($sformatf("b_bcd_n%0d", n), 32'({b_tens, b_ones}), 32'({4'(br / 10), 4'(br % 10)}));
            chk("a_bcd_vs_rem", 32'(a_tens * 10 + a_ones), 32'(a_remain));
            chk("b_bcd_vs_rem", 32'(b_tens * 10 + b_ones), 32'(b_remain));
        end
    endtask

    task automatic tick(input int n);
        int exp_n;
        number = 7'(n);
        @(posedge clk_1s);
        #1;
        if (m_flt) begin
            if (n == 0) m_flt = 1'b0;
            else        m_flash = !m_flash;
        end else begin
            exp_n = (m_nq == 58) ? 0 : m_nq + 1;
            if (n != exp_n || n >= 59) begin
                m_flt   = 1'b1;
                m_flash = 1'b1;
            end
        end
        m_nq = n;
        check_all(n);
    endtask

    // Assert reset 3 time units after an edge, away from any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset(tag);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        number = 7'd0;
        model_reset();
        #12;
        check_reset("por");
        rst = 1'b0;

        // Test 1: one full cycle
        for (int n = 0; n < 59; n++) begin
            tick(n);
            if (n == 0)  chk("t1_n0_a_rem", 32'(a_remain), 30);
            if (n == 29) chk("t1_n29_a_rem", 32'(a_remain), 1);
            if (n == 58) chk("t1_n58_rem", 32'({a_remain, b_remain}), 32'({7'd1, 7'd1}));
        end

        // Test 2: two more cycles through the wrap
        for (int c = 0; c < 2; c++)
            for (int n = 0; n < 59; n++) tick(n);
        tick(0);
        chk("t2_fault", 32'(fault), 0);
        chk("t2_a_grn", 32'(a_grn), 1);
        chk("t2_a_bcd", 32'({a_tens, a_ones}), 32'h30);

        // Test 3: skip 10 -> 15, flash, resync on 0
        for (int n = 1; n <= 10; n++) tick(n);
        tick(15);
        chk("t3_fault", 32'(fault), 1);
        chk("t3_yel1", 32'({a_yel, b_yel}), 32'b11);
        tick(16);
        chk("t3_yel0", 32'({a_yel, b_yel}), 32'b00);
        tick(17);
        chk("t3_yel1b", 32'({a_yel, b_yel}), 32'b11);
        tick(0);
        chk("t3_exit", 32'({fault, a_grn, a_remain}), 32'({1'b0, 1'b1, 7'd30}));

        // Test 4: out-of-range index
        for (int n = 1; n <= 5; n++) tick(n);
        tick(70);
        chk("t4_fault", 32'(fault), 1);
        chk("t4_rg_off", 32'({a_red, a_grn, b_red, b_grn}), 0);
        tick(0);

        // Test 5a: reset while flashing
        tick(1);
        tick(9);
        chk("t5a_in_flt", 32'(fault), 1);
        async_reset("t5a_rst");
        tick(0);
        chk("t5a_nofault", 32'(fault), 0);

        // Test 5b: reset mid B green
        for (int n = 1; n <= 40; n++) tick(n);
        chk("t5b_b_grn", 32'(b_grn), 1);
        async_reset("t5b_rst");
        tick(0);
        chk("t5b_nofault", 32'(fault), 0);
        tick(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
